// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, ALU operation codes, the
// ID/EX control bundle and its bubble value.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    // Registered control fields of the ID/EX slot.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       src_pc;
        logic       src_imm;
        logic [3:0] alu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } idex_ctrl_t;

    // Bubble: nothing valid, no side effects, rs = x0 so no forward matches.
    localparam idex_ctrl_t BUBBLE_CTRL = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        src_pc:    1'b0,
        src_imm:   1'b0,
        alu_op:    ALU_NOP,
        rd:        5'd0,
        rs1:       5'd0,
        rs2:       5'd0
    };

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SRL) || (op == ALU_SRA) || (op == ALU_SLL);
    endfunction

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding mux for one source register.
// Ports: rs / rf_data       - registered source address and register-file data
//        exmem_* / memwb_*  - write-back triples of the two downstream stages
//        fwd_data           - newest value of rs (EX/MEM over MEM/WB over RF)
module forward_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] fwd_data
);

    // x0 is hard-wired zero, so a write to it is never forwarded.
    always_comb begin
        fwd_data = rf_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
            fwd_data = exmem_data;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports: clk/rst (sync, active-high), stall/flush pipeline control,
//        id_*      - decoded instruction fields from decode,
//        exmem_*/memwb_* - forwarding sources,
//        alu_in1/alu_in2/alu_op - ALU operands and operation,
//        ex_*      - registered control, destination, PC and store data,
//        load_use_hazard - combinational; decode must hold its instruction.
import riscv_pkg::*;

module id_ex_stage #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src_pc,
    input  logic            id_src_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_hazard
);

    idex_ctrl_t      ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] in2_sel;
    idex_ctrl_t      id_ctrl;

    // Conservative: rs2 is compared even if the decoded instruction ignores it.
    always_comb begin
        load_use_hazard = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                          id_valid && ((ctrl_q.rd == id_rs1) || (ctrl_q.rd == id_rs2));
    end

    always_comb begin
        id_ctrl           = BUBBLE_CTRL;
        id_ctrl.valid     = 1'b1;
        id_ctrl.reg_write = id_reg_write;
        id_ctrl.mem_read  = id_mem_read;
        id_ctrl.mem_write = id_mem_write;
        id_ctrl.src_pc    = id_src_pc;
        id_ctrl.src_imm   = id_src_imm;
        id_ctrl.alu_op    = id_alu_op;
        id_ctrl.rd        = id_rd;
        id_ctrl.rs1       = id_rs1;
        id_ctrl.rs2       = id_rs2;
    end

    // Priority: reset, flush, stall (hold), hazard bubble, empty slot bubble, load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrl_q     <= BUBBLE_CTRL;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (stall) begin
            ctrl_q     <= ctrl_q;
            pc_q       <= pc_q;
            rs1_data_q <= rs1_data_q;
            rs2_data_q <= rs2_data_q;
            imm_q      <= imm_q;
        end else if (load_use_hazard || !id_valid) begin
            ctrl_q     <= BUBBLE_CTRL;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            ctrl_q     <= id_ctrl;
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
        end
    end

    forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs              (ctrl_q.rs1),
        .rf_data         (rs1_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_data      (exmem_data),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (fwd_rs1)
    );

    forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs              (ctrl_q.rs2),
        .rf_data         (rs2_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_data      (exmem_data),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (fwd_rs2)
    );

    always_comb begin
        alu_in1 = ctrl_q.src_pc ? pc_q : fwd_rs1;
        in2_sel = ctrl_q.src_imm ? imm_q : fwd_rs2;
        alu_in2 = in2_sel;
        // Shifts consume only the 5-bit shift amount.
        if (is_shift(ctrl_q.alu_op)) begin
            alu_in2 = {{(XLEN-5){1'b0}}, in2_sel[4:0]};
        end
    end

    assign alu_op        = ctrl_q.alu_op;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_rd         = ctrl_q.rd;
    assign ex_pc         = pc_q;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_src_pc, id_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_in1, alu_in2, ex_pc, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_src_pc(id_src_pc), .id_src_imm(id_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .load_use_hazard(load_use_hazard)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        logic        valid, rw, mr, mw, spc, simm;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, d1, d2, imm;
    } slot_t;

    slot_t m;
    logic  m_ok = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    logic [3:0] op_tbl [11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'h9, 4'h5,
                                4'hC, 4'hD, 4'hA, 4'hF};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t bubble();
        slot_t b;
        b = '{valid: 0, rw: 0, mr: 0, mw: 0, spc: 0, simm: 0, op: 4'hF,
              rd: 0, rs1: 0, rs2: 0, pc: 0, d1: 0, d2: 0, imm: 0};
        return b;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_data;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_data;
        return d;
    endfunction

    function automatic logic m_hazard();
        return m.valid && m.mr && m.rd != 0 && id_valid &&
               (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic compare_all();
        logic [31:0] e1, e2;
        e1 = m.spc ? m.pc : m_fwd(m.rs1, m.d1);
        e2 = m.simm ? m.imm : m_fwd(m.rs2, m.d2);
        if (m.op == 4'h8 || m.op == 4'h9 || m.op == 4'hA) e2 = e2 % 32;
        check_eq("ex_valid", ex_valid, m.valid);
        check_eq("ex_reg_write", ex_reg_write, m.rw);
        check_eq("ex_mem_read", ex_mem_read, m.mr);
        check_eq("ex_mem_write", ex_mem_write, m.mw);
        check_eq("ex_rd", ex_rd, m.rd);
        check_eq("ex_pc", ex_pc, m.pc);
        check_eq("alu_op", alu_op, m.op);
        check_eq("alu_in1", alu_in1, e1);
        check_eq("alu_in2", alu_in2, e2);
        check_eq("ex_store_data", ex_store_data, m_fwd(m.rs2, m.d2));
        check_eq("load_use_hazard", load_use_hazard, m_hazard());
    endtask

    // Called at a negedge with inputs set: check, clock once, advance model.
    task automatic step();
        logic hz;
        #1;
        if (m_ok) compare_all();
        hz = m_hazard();
        @(posedge clk);
        if (rst || flush) begin
            m = bubble();
            if (rst) m_ok = 1'b1;
        end else if (stall) begin
            m = m;
        end else if (hz || !id_valid) begin
            m = bubble();
        end else begin
            m = '{valid: 1, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                  spc: id_src_pc, simm: id_src_imm, op: id_alu_op, rd: id_rd,
                  rs1: id_rs1, rs2: id_rs2, pc: id_pc, d1: id_rs1_data,
                  d2: id_rs2_data, imm: id_imm};
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; stall = 0; flush = 0; id_valid = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 4'h2;
        id_src_pc = 0; id_src_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_data = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2);
        id_valid = 1; id_alu_op = op; id_rd = rd; id_reg_write = 1;
        id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_mem_read = 0; id_mem_write = 0; id_src_pc = 0; id_src_imm = 0;
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 39) == 0);
        flush = ($urandom_range(0, 11) == 0);
        stall = ($urandom_range(0, 5) == 0);
        id_valid = ($urandom_range(0, 4) != 0);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_alu_op = op_tbl[$urandom_range(0, 10)];
        id_src_pc = 1'($urandom); id_src_imm = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
        id_mem_write = 1'($urandom);
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
        exmem_data = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
        memwb_data = $urandom;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);

        // Reset wins over stall and flush.
        rst = 1; stall = 1; flush = 1;
        set_id(4'h2, 5'd3, 5'd1, 32'h11, 5'd2, 32'h22);
        step();
        clear_inputs();
        #1;
        check_eq("rst_valid", ex_valid, 1'b0);
        check_eq("rst_alu_op", alu_op, 4'hF);
        check_eq("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b000);
        check_eq("rst_in1", alu_in1, 32'h0);

        // Forwarding priority.
        set_id(4'h2, 5'd1, 5'd5, 32'd10, 5'd6, 32'd20);
        step();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_data = 32'd100;
        memwb_reg_write = 1; memwb_rd = 5'd6; memwb_data = 32'd200;
        #1;
        check_eq("fwd_exmem_in1", alu_in1, 32'd100);
        check_eq("fwd_memwb_in2", alu_in2, 32'd200);
        memwb_rd = 5'd5;
        #1;
        check_eq("fwd_priority", alu_in1, 32'd100);
        step();

        // x0 is never forwarded.
        clear_inputs();
        set_id(4'h2, 5'd1, 5'd0, 32'd0, 5'd2, 32'd4);
        step();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_data = 32'hDEAD;
        #1;
        check_eq("x0_no_fwd", alu_in1, 32'd0);
        step();

        // Load-use hazard: exactly one bubble, then the consumer issues.
        clear_inputs();
        set_id(4'h2, 5'd7, 5'd1, 32'h100, 5'd0, 32'd0);
        id_mem_read = 1; id_src_imm = 1; id_imm = 32'd8;
        step();
        set_id(4'h6, 5'd9, 5'd7, 32'd1, 5'd3, 32'd2);
        #1;
        check_eq("lu_hazard", load_use_hazard, 1'b1);
        step();
        #1;
        check_eq("lu_bubble", ex_valid, 1'b0);
        check_eq("lu_cleared", load_use_hazard, 1'b0);
        step();
        #1;
        check_eq("lu_issue_valid", ex_valid, 1'b1);
        check_eq("lu_issue_op", alu_op, 4'h6);

        // Shift amount masking.
        clear_inputs();
        set_id(4'h8, 5'd2, 5'd1, 32'd5, 5'd0, 32'd0);
        id_src_imm = 1; id_imm = 32'hFFFFFFE3;
        step();
        #1;
        check_eq("srl_mask", alu_in2, 32'h00000003);
        id_alu_op = 4'h2;
        step();
        #1;
        check_eq("add_nomask", alu_in2, 32'hFFFFFFE3);

        // Stall holds for three cycles; stall with flush yields a bubble.
        clear_inputs();
        set_id(4'h0, 5'd4, 5'd1, 32'd3, 5'd2, 32'd4);
        id_pc = 32'h1234;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = $urandom; id_rd = 5'($urandom_range(1, 31));
            step();
            #1;
            check_eq("stall_pc", ex_pc, 32'h1234);
            check_eq("stall_rd", ex_rd, 5'd4);
        end
        flush = 1;
        step();
        #1;
        check_eq("stall_flush_valid", ex_valid, 1'b0);
        check_eq("stall_flush_op", alu_op, 4'hF);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
